// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential shift-and-add multiplier, unsigned or two's-complement signed
module shift_add_mul #(
  parameter int W = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic            sgn,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [2*W-1:0]  y,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   q
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2*W-1:0] ra, acc, acc_n;
  logic [W-1:0] rb, ma, mb;
  logic neg, start, last;
  // Next state, operand magnitudes and the next accumulator value
  always_comb begin
    start = ld && state != CALC;
    last = q == CW'(W - 1);
    state_n = start ? CALC : (state == CALC && last) ? DONE : state;
    ma = sgn && a[W-1] ? -a : a;
    mb = sgn && b[W-1] ? -b : b;
    acc_n = rb[0] ? acc + ra : acc;
  end
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // Datapath and registered outputs; the sign is applied once, after the last add
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ra <= '0;
      rb <= '0;
      acc <= '0;
      neg <= 1'b0;
      y <= '0;
      q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      ra <= {{W{1'b0}}, ma};
      rb <= mb;
      neg <= sgn & (a[W-1] ^ b[W-1]);
      acc <= '0;
      y <= '0;
      q <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == CALC) begin
      acc <= acc_n;
      ra <= ra << 1;
      rb <= rb >> 1;
      q <= q + 1'b1;
      if (last) begin
        y <= neg ? -acc_n : acc_n;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule
